// File: rtl/verdict_ser_pkg.sv
// Shared types and helpers for the monitor verdict serializer.
package verdict_ser_pkg;

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  localparam int unsigned DEF_NUM_OUTPUTS = 10;
  localparam int unsigned DEF_DATA_W      = 64;
  localparam int unsigned DEF_TS_W        = 32;

  localparam int unsigned IDX_W  = $clog2(DEF_NUM_OUTPUTS);
  localparam int unsigned SNAP_W = DEF_TS_W + DEF_NUM_OUTPUTS + DEF_NUM_OUTPUTS * DEF_DATA_W;
  localparam int unsigned DROP_W = 16;

  // Widest activity mask lowest_set can scan; callers zero-extend narrower masks.
  localparam int unsigned MAX_OUTPUTS = 64;

  function automatic int unsigned lowest_set(input logic [MAX_OUTPUTS-1:0] mask);
    lowest_set = 0;
    for (int i = MAX_OUTPUTS - 1; i >= 0; i--) begin
      if (mask[i]) lowest_set = unsigned'(i);
    end
  endfunction

endpackage

// File: rtl/monitor_verdict_serializer_snapshot_fifo.sv
// Snapshot FIFO; a push and a pop on the same edge both succeed even when full.
module snapshot_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [Width-1:0] head
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic             wr_en, rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]) &&
                 (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);
  assign head  = mem_q[rd_ptr_q[AddrW-1:0]];

  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AddrW-1:0]] <= din;
  end

endmodule

// File: rtl/monitor_verdict_serializer.sv
// Captures active monitor outputs as timestamped snapshots and drains them as per-output records.
module monitor_verdict_serializer
  import verdict_ser_pkg::*;
#(
  parameter int unsigned NUM_OUTPUTS = 10,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned TS_W        = 32,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_OUTPUTS*DATA_W-1:0] out_data,
  input  logic [NUM_OUTPUTS-1:0]        out_aktv,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [TS_W-1:0]               m_ts,
  output logic [$clog2(NUM_OUTPUTS)-1:0] m_idx,
  output logic [DATA_W-1:0]             m_data,
  output logic                          m_last,
  output logic                          overflow,
  output logic [DROP_W-1:0]             drop_cnt
);

  localparam int unsigned IdxW  = $clog2(NUM_OUTPUTS);
  localparam int unsigned SnapW = TS_W + NUM_OUTPUTS + NUM_OUTPUTS * DATA_W;

  state_e                        state_q, state_d;
  logic [TS_W-1:0]               ts_q;
  logic [TS_W-1:0]               wts_q, wts_d;
  logic [NUM_OUTPUTS-1:0]        wmask_q, wmask_d;
  logic [NUM_OUTPUTS*DATA_W-1:0] wdata_q, wdata_d;
  logic                          overflow_q;
  logic [DROP_W-1:0]             drop_q;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [SnapW-1:0] fifo_head, snap_in;
  logic             capture, drop;
  logic             emitting, cur_last;
  logic [IdxW-1:0]  cur_idx;
  logic [DATA_W-1:0] cur_data;

  assign snap_in   = {ts_q, out_aktv, out_data};
  assign capture   = en & (|out_aktv);
  assign fifo_push = capture & (~fifo_full | fifo_pop);
  assign drop      = capture & fifo_full & ~fifo_pop;

  snapshot_fifo #(
    .Width (SnapW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (snap_in),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign emitting = (state_q == StEmit);
  assign cur_idx  = IdxW'(lowest_set(MAX_OUTPUTS'(wmask_q)));
  assign cur_data = wdata_q[cur_idx*DATA_W +: DATA_W];
  assign cur_last = (wmask_q != '0) && ((wmask_q & (wmask_q - NUM_OUTPUTS'(1))) == '0);

  // Outputs are zero outside EMIT so idle values match the reset values.
  assign m_valid  = emitting;
  assign m_ts     = emitting ? wts_q : '0;
  assign m_idx    = emitting ? cur_idx : '0;
  assign m_data   = emitting ? cur_data : '0;
  assign m_last   = emitting & cur_last;
  assign overflow = overflow_q;
  assign drop_cnt = drop_q;

  always_comb begin
    state_d  = state_q;
    wts_d    = wts_q;
    wmask_d  = wmask_q;
    wdata_d  = wdata_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = StEmit;
        end
      end
      StEmit: begin
        if (m_ready) begin
          wmask_d = wmask_q & ~(NUM_OUTPUTS'(1) << cur_idx);
          // Chain straight into the next snapshot to avoid an idle bubble.
          if (cur_last) begin
            if (!fifo_empty) fifo_pop = 1'b1;
            else             state_d  = StIdle;
          end
        end
      end
    endcase
    if (fifo_pop) {wts_d, wmask_d, wdata_d} = fifo_head;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      ts_q       <= '0;
      wts_q      <= '0;
      wmask_q    <= '0;
      wdata_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q <= state_d;
      wts_q   <= wts_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      if (en) ts_q <= ts_q + TS_W'(1);
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != {DROP_W{1'b1}}) drop_q <= drop_q + DROP_W'(1);
      end
    end
  end

endmodule
